// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Instruction-in / control-bundle-out channel of decode_stage.
//               slave  = decoder view, master = fetch/execute environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int ALU_CTRL_W = 4,
    parameter int TAG_W      = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic                  out_valid;
    logic                  out_ready;
    logic [ALU_CTRL_W-1:0] out_alu_control;
    logic [1:0]            out_mux4selector;
    logic                  out_destination_indicator;
    logic [4:0]            out_dest_reg;
    logic                  out_reg_write;
    logic                  out_flag_lw;
    logic                  out_flag_sw;
    logic                  out_flag_R_type;
    logic                  out_flag_I_type;
    logic                  out_flag_J_type;
    logic                  out_branch;
    logic                  out_jump;
    logic                  out_bubble;
    logic [TAG_W-1:0]      out_tag;
    logic                  out_illegal;
    logic                  err_sticky;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_alu_control, out_mux4selector,
               out_destination_indicator, out_dest_reg, out_reg_write,
               out_flag_lw, out_flag_sw, out_flag_R_type, out_flag_I_type,
               out_flag_J_type, out_branch, out_jump, out_bubble, out_tag,
               out_illegal, err_sticky
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_alu_control, out_mux4selector,
               out_destination_indicator, out_dest_reg, out_reg_write,
               out_flag_lw, out_flag_sw, out_flag_R_type, out_flag_I_type,
               out_flag_J_type, out_branch, out_jump, out_bubble, out_tag,
               out_illegal, err_sticky
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered MIPS decoder. Decodes R/I/J instructions into a
//               control bundle, inserts a one-cycle bubble on load-use
//               hazards and queues entries (DEPTH deep) toward execute.
//               Optional macro DECODE_ILLEGAL_TRAP_EN flags unlisted
//               encodings (out_illegal, err_sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int DEPTH      = 2,
    parameter int ALU_CTRL_W = 4,
    parameter int TAG_W      = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    decode_stage_if.slave bus
);

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit c_TRAP_EN = 1'b1;
`else
    localparam bit c_TRAP_EN = 1'b0;
`endif

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu_control;
        logic [1:0]            mux4selector;
        logic                  destination_indicator;
        logic [4:0]            dest_reg;
        logic                  reg_write;
        logic                  flag_lw;
        logic                  flag_sw;
        logic                  flag_r_type;
        logic                  flag_i_type;
        logic                  flag_j_type;
        logic                  branch;
        logic                  jump;
        logic                  bubble;
        logic [TAG_W-1:0]      tag;
        logic                  illegal;
    } entry_t;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_BUBBLE = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_ld_valid;
    logic [4:0]           r_ld_dest;
    entry_t               r_pending;
    logic                 r_err_sticky;

    entry_t               w_dec, w_bubble, w_push_entry, w_head;
    logic                 w_unlisted, w_uses_rt, w_hazard;
    logic                 w_in_ready, w_accept, w_push, w_pop, w_pend_load;
    logic                 w_out_valid;
    logic [5:0]           w_opcode, w_funct;
    logic [4:0]           w_rs, w_rt, w_rd;

    assign w_opcode = bus.in_instr[31:26];
    assign w_rs     = bus.in_instr[25:21];
    assign w_rt     = bus.in_instr[20:16];
    assign w_rd     = bus.in_instr[15:11];
    assign w_funct  = bus.in_instr[5:0];

    // Instruction word to control bundle; unlisted encodings fall back to add.
    always_comb begin
        w_dec          = '0;
        w_unlisted     = 1'b0;
        w_dec.tag      = r_tag;
        w_dec.dest_reg = w_rt;
        case (w_opcode)
            6'h00: begin
                w_dec.flag_r_type           = 1'b1;
                w_dec.destination_indicator = 1'b1;
                w_dec.dest_reg              = w_rd;
                w_dec.reg_write             = 1'b1;
                case (w_funct)
                    6'h00:   w_dec.alu_control = ALU_CTRL_W'(4'd8);
                    6'h02:   w_dec.alu_control = ALU_CTRL_W'(4'd9);
                    6'h20:   w_dec.alu_control = ALU_CTRL_W'(4'd2);
                    6'h22:   w_dec.alu_control = ALU_CTRL_W'(4'd3);
                    6'h24:   w_dec.alu_control = ALU_CTRL_W'(4'd5);
                    6'h25:   w_dec.alu_control = ALU_CTRL_W'(4'd6);
                    6'h2A:   w_dec.alu_control = ALU_CTRL_W'(4'd7);
                    6'h08: begin
                        w_dec.alu_control = ALU_CTRL_W'(4'd2);
                        w_dec.jump        = 1'b1;
                        w_dec.reg_write   = 1'b0;
                    end
                    default: begin
                        w_dec.alu_control = ALU_CTRL_W'(4'd2);
                        w_unlisted        = 1'b1;
                    end
                endcase
            end
            6'h08: begin
                w_dec.flag_i_type  = 1'b1;
                w_dec.alu_control  = ALU_CTRL_W'(4'd2);
                w_dec.mux4selector = 2'd2;
                w_dec.reg_write    = 1'b1;
            end
            6'h0C: begin
                w_dec.flag_i_type  = 1'b1;
                w_dec.alu_control  = ALU_CTRL_W'(4'd5);
                w_dec.mux4selector = 2'd1;
                w_dec.reg_write    = 1'b1;
            end
            6'h0D: begin
                w_dec.flag_i_type  = 1'b1;
                w_dec.alu_control  = ALU_CTRL_W'(4'd6);
                w_dec.mux4selector = 2'd1;
                w_dec.reg_write    = 1'b1;
            end
            6'h0F: begin
                w_dec.flag_i_type  = 1'b1;
                w_dec.alu_control  = ALU_CTRL_W'(4'd11);
                w_dec.mux4selector = 2'd3;
                w_dec.reg_write    = 1'b1;
            end
            6'h23: begin
                w_dec.flag_i_type = 1'b1;
                w_dec.flag_lw     = 1'b1;
                w_dec.alu_control = ALU_CTRL_W'(4'd10);
                w_dec.reg_write   = 1'b1;
            end
            6'h2B: begin
                w_dec.flag_i_type = 1'b1;
                w_dec.flag_sw     = 1'b1;
                w_dec.alu_control = ALU_CTRL_W'(4'd2);
            end
            6'h04, 6'h05: begin
                w_dec.flag_i_type = 1'b1;
                w_dec.branch      = 1'b1;
                w_dec.alu_control = ALU_CTRL_W'(4'd10);
            end
            6'h02: begin
                w_dec.flag_j_type = 1'b1;
                w_dec.jump        = 1'b1;
                w_dec.alu_control = ALU_CTRL_W'(4'd2);
            end
            6'h03: begin
                w_dec.flag_j_type = 1'b1;
                w_dec.jump        = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.dest_reg    = 5'd31;
                w_dec.alu_control = ALU_CTRL_W'(4'd2);
            end
            default: begin
                w_dec.alu_control = ALU_CTRL_W'(4'd2);
                w_dec.reg_write   = 1'b1;
                w_unlisted        = 1'b1;
            end
        endcase
        if (c_TRAP_EN && w_unlisted) begin
            w_dec.illegal   = 1'b1;
            w_dec.reg_write = 1'b0;
            w_dec.flag_lw   = 1'b0;
            w_dec.flag_sw   = 1'b0;
        end
    end

    // Load-use check against the destination of the last pushed lw.
    always_comb begin
        w_uses_rt = (w_opcode == 6'h00) || (w_opcode == 6'h2B) ||
                    (w_opcode == 6'h04) || (w_opcode == 6'h05);
        w_hazard  = r_ld_valid && (r_ld_dest != 5'd0) &&
                    ((w_rs == r_ld_dest) || (w_uses_rt && (w_rt == r_ld_dest)));
        w_bubble        = '0;
        w_bubble.bubble = 1'b1;
        w_bubble.tag    = r_tag;
    end

    assign w_in_ready  = (r_state == S_IDLE) && (r_count < c_DEPTH_CNT);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    // Next state and queue push selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_entry = w_dec;
        w_pend_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_push = 1'b1;
                    if (w_hazard) begin
                        w_push_entry = w_bubble;
                        w_pend_load  = 1'b1;
                        w_state_nxt  = S_BUBBLE;
                    end
                end
            end
            S_BUBBLE: begin
                if (r_count < c_DEPTH_CNT) begin
                    w_push       = 1'b1;
                    w_push_entry = r_pending;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control state: FSM, pointers, occupancy, tag, hazard tracker, sticky error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_tag        <= '0;
            r_ld_valid   <= 1'b0;
            r_ld_dest    <= '0;
            r_pending    <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_accept) r_tag <= r_tag + 1'b1;
            if (w_pend_load) r_pending <= w_dec;
            if (w_push && !w_push_entry.bubble) begin
                r_ld_valid <= w_push_entry.flag_lw;
                r_ld_dest  <= w_push_entry.dest_reg;
            end
            if (c_TRAP_EN && w_push && w_push_entry.illegal) r_err_sticky <= 1'b1;
        end
    end

    // Queue storage; contents are only visible through a valid head.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
    end

    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.in_ready                  = w_in_ready;
    assign bus.out_valid                 = w_out_valid;
    assign bus.out_alu_control           = w_head.alu_control;
    assign bus.out_mux4selector          = w_head.mux4selector;
    assign bus.out_destination_indicator = w_head.destination_indicator;
    assign bus.out_dest_reg              = w_head.dest_reg;
    assign bus.out_reg_write             = w_head.reg_write;
    assign bus.out_flag_lw               = w_head.flag_lw;
    assign bus.out_flag_sw               = w_head.flag_sw;
    assign bus.out_flag_R_type           = w_head.flag_r_type;
    assign bus.out_flag_I_type           = w_head.flag_i_type;
    assign bus.out_flag_J_type           = w_head.flag_j_type;
    assign bus.out_branch                = w_head.branch;
    assign bus.out_jump                  = w_head.jump;
    assign bus.out_bubble                = w_head.bubble;
    assign bus.out_tag                   = w_head.tag;
    assign bus.out_illegal               = c_TRAP_EN ? w_head.illegal : 1'b0;
    assign bus.err_sticky                = c_TRAP_EN ? r_err_sticky : 1'b0;

endmodule
`default_nettype wire
